// File: rtl/rf_write_arbiter_pkg.sv
// rf_pkg: shared widths and output-register reset constants for the register-file write arbiter.
package rf_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int RF_CNT_W = 16;
  localparam logic RF_RST_WE = 1'b0;
  localparam logic [RF_AW-1:0] RF_RST_WREG = '0;
  localparam logic [RF_DW-1:0] RF_RST_WDATA = '0;
  localparam logic [2:0] RF_RST_GID = '0;
  localparam logic [RF_CNT_W-1:0] RF_RST_CNT = '0;
endpackage

// File: rtl/rf_write_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant, first requester strictly after the last granted index.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gntIdx
);
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic found;
  always_comb begin
    gnt = '0;
    gntIdx = ptr;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gntIdx = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= PW'(N - 1);
    else if (adv) ptr <= gntIdx;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port among NREQ writeback sources, yielding to reads.
// Define RF_ARB_ZERO_GUARD_EN to swallow writes to register 0 (accepted but never strobed).
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 read_req,
  output logic                 RegWrite,
  output logic [AW-1:0]        WriteRegister,
  output logic [DW-1:0]        WriteData_reg,
  output logic [2:0]           grant_id,
  output logic [RF_CNT_W-1:0]  write_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0] gntIdx;
  logic xfer;
  logic doWrite;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selData;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(clk), .rst(rst), .req(req_valid), .en(!read_req), .adv(xfer),
    .gnt(gnt), .gntIdx(gntIdx)
  );
  assign req_ready = gnt;
  assign xfer = |gnt;
  assign selAddr = req_addr[int'(gntIdx)*AW +: AW];
  assign selData = req_data[int'(gntIdx)*DW +: DW];
`ifdef RF_ARB_ZERO_GUARD_EN
  assign doWrite = xfer && (selAddr != '0);
`else
  assign doWrite = xfer;
`endif
  // The count advances on the same edge that raises RegWrite, so it reflects the strobe being shown.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      RegWrite <= RF_RST_WE;
      WriteRegister <= AW'(RF_RST_WREG);
      WriteData_reg <= DW'(RF_RST_WDATA);
      grant_id <= RF_RST_GID;
      write_count <= RF_RST_CNT;
    end else begin
      RegWrite <= doWrite;
      write_count <= write_count + RF_CNT_W'(doWrite);
      if (xfer) begin
        WriteRegister <= selAddr;
        WriteData_reg <= selData;
        grant_id <= 3'(gntIdx);
      end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench for the two-requester register-file write arbiter.
module tb_rf_write_arbiter;
`ifdef RF_ARB_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [2:0]  id;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] v = '0;
  logic [4:0] a [2];
  logic [31:0] d [2];
  logic rd = 1'b0;
  logic [1:0] req_ready;
  logic RegWrite;
  logic [4:0] WriteRegister;
  logic [31:0] WriteData_reg;
  logic [2:0] grant_id;
  logic [15:0] write_count;
  item_t sb [$];
  int errs = 0;
  int checks = 0;
  int mptr = 1;
  logic [15:0] cnt = '0;
  always #5 clk = ~clk;
  rf_write_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_addr({a[1], a[0]}), .req_data({d[1], d[0]}),
    .req_ready(req_ready), .read_req(rd), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData_reg(WriteData_reg), .grant_id(grant_id), .write_count(write_count)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_we", 32'(RegWrite), 0);
    check("rst_wreg", 32'(WriteRegister), 0);
    check("rst_wdata", WriteData_reg, 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_cnt", 32'(write_count), 0);
    @(negedge clk);
    rst = 1'b0;
    v = '0;
    rd = 1'b0;
    mptr = 1;
    cnt = '0;
    sb.delete();
  endtask
  task automatic cycle(input bit keep);
    logic [1:0] er;
    int gi;
    bit we;
    item_t it;
    #1;
    er = 2'b00;
    if (!rd && v == 2'b11) er = (mptr == 0) ? 2'b10 : 2'b01;
    else if (!rd) er = v;
    check("ready", 32'(req_ready), 32'(er));
    gi = (er == 2'b10) ? 1 : (er == 2'b01) ? 0 : -1;
    we = 1'b0;
    if (gi >= 0) begin
      sb.push_back('{a[gi], d[gi], 3'(gi)});
      mptr = gi;
      we = !(GUARD && a[gi] == 5'd0);
    end
    @(posedge clk);
    #1;
    check("RegWrite", 32'(RegWrite), 32'(we));
    if (gi >= 0) begin
      it = sb.pop_front();
      check("WriteRegister", 32'(WriteRegister), 32'(it.a));
      check("WriteData_reg", WriteData_reg, it.d);
      check("grant_id", 32'(grant_id), 32'(it.id));
      if (!keep) v[gi] = 1'b0;
    end
    cnt = cnt + 16'(we);
    check("write_count", 32'(write_count), 32'(cnt));
    @(negedge clk);
  endtask
  initial begin
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    do_reset();
    // alternating service with both sources held valid
    a[0] = 5'd3; d[0] = 32'hA; a[1] = 5'd7; d[1] = 32'hB; v = 2'b11;
    repeat (4) cycle(1'b1);
    v = '0;
    cycle(1'b0);
    do_reset();
    a[1] = 5'd9; d[1] = 32'h1234; v = 2'b10;
    cycle(1'b0);
    cycle(1'b0);
    // read cycles block the pending write
    a[0] = 5'd4; d[0] = 32'h55; v = 2'b01; rd = 1'b1;
    repeat (3) cycle(1'b0);
    rd = 1'b0;
    cycle(1'b0);
    do_reset();
    a[0] = 5'd5; d[0] = 32'h11; a[1] = 5'd5; d[1] = 32'h22; v = 2'b11;
    cycle(1'b0);
    cycle(1'b0);
    check("sb_empty", 32'(sb.size()), 0);
    a[1] = 5'd0; d[1] = 32'hDEAD; v = 2'b10;
    cycle(1'b0);
    a[0] = 5'd0; d[0] = 32'hBEEF; v = 2'b01;
    cycle(1'b0);
    // asynchronous reset while a strobe is showing
    a[0] = 5'd2; d[0] = 32'h77; v = 2'b01;
    @(posedge clk);
    #1 check("pre_rst_we", 32'(RegWrite), 1);
    v = '0;
    do_reset();
    // drive the counter to its top value, then wrap
    a[0] = 5'd1; d[0] = 32'h1; v = 2'b01;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    v = '0;
    #1 check("cnt_full", 32'(write_count), 32'h0000_FFFF);
    mptr = 0;
    cnt = 16'hFFFF;
    @(negedge clk);
    v = 2'b01;
    cycle(1'b0);
    check("cnt_wrap", 32'(write_count), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
